mux8_rr_arbiter: RTL

Round-robin arbiter that shares one 8-to-1 data mux among eight requesters. It produces the registered 3-bit mux select plus a one-hot grant vector, holds each grant while the owner keeps requesting, and rotates priority so that no requester starves. It sits directly in front of the mux select inputs in the shared-resource datapath.

---
 rtl/mux8_rr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter driving the select of a shared 8:1 mux.
// Ports: clk, rst_n (async low), arb_en, req[0:7] in; grant[0:7], sel[2:0], valid out.
// Optional hold limit: define MUX8_ARB_HOLD_LIMIT_EN to cap a grant at MAX_HOLD cycles.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arb_en,
    input  logic [0:7] req,
    output logic [0:7] grant,
    output logic [2:0] sel,
    output logic       valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [2:0] owner, owner_n;
    logic [0:7] grant_n;
    logic       valid_n;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    logic       hold_limit;

`ifdef MUX8_ARB_HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt, hold_n;

    assign hold_limit = (hold_cnt == HW'(MAX_HOLD - 1));
`else
    assign hold_limit = 1'b0;
`endif

    // Scan ptr, ptr+1, ... ptr+7; walking backwards lets the
    // closest-to-ptr request overwrite any farther one.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        idx   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        grant_n = grant;
        valid_n = valid;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
        hold_n  = hold_cnt;
`endif
        unique case (state)
            IDLE: begin
                grant_n = '0;
                valid_n = 1'b0;
                if (arb_en && found) begin
                    state_n       = GRANT;
                    owner_n       = pick;
                    grant_n[pick] = 1'b1;
                    valid_n       = 1'b1;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
                    hold_n        = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[owner] || hold_limit) begin
                    // Release: the old owner drops to lowest priority.
                    state_n = IDLE;
                    grant_n = '0;
                    valid_n = 1'b0;
                    ptr_n   = owner + 3'd1;
                end else begin
`ifdef MUX8_ARB_HOLD_LIMIT_EN
                    if (hold_cnt != '1) begin
                        hold_n = hold_cnt + 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            owner    <= 3'd0;
            grant    <= '0;
            valid    <= 1'b0;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            grant    <= grant_n;
            valid    <= valid_n;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
            hold_cnt <= hold_n;
`endif
        end
    end

    assign sel = owner;

endmodule
